// File: rtl/rr_grant_ctrl8_pkg.sv
// Shared definitions for the eight-way round-robin grant controller and its picker.
package rr_grant_ctrl8_pkg;

  localparam int N            = 8;
  localparam int IDW          = 3;
  localparam int MAX_HOLD_DEF = 16;
  localparam int HOLD_W       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] id);
    logic [N-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_grant_ctrl8_pick8.sv
// Combinational rotated priority encoder: first set request at or above ptr, wrapping 7->0.
module rr_pick8
  import rr_grant_ctrl8_pkg::*;
(
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] win_id,
  output logic           any
);

  logic [N-1:0]   rot;
  logic [IDW-1:0] off;

  // Index arithmetic is IDW bits wide, so ptr+i wraps modulo 8 for free.
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[IDW'(i) + ptr];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    win_id = ptr + off;
    any    = |req;
  end

endmodule

// File: rtl/rr_grant_ctrl8.sv
// Round-robin owner controller: grants one of eight requesters and holds it until done, withdrawal or hold limit.
module rr_grant_ctrl8
  import rr_grant_ctrl8_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           idle,
  output logic           timeout
);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;

  logic [IDW-1:0]     win_id;
  logic               any;
  logic               at_limit;
  logic               owner_req;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .win_id (win_id),
    .any    (any)
  );

  assign at_limit  = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign owner_req = req[id_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          gnt_d   = onehot(win_id);
          id_d    = win_id;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (done || !owner_req || at_limit) begin
          // timeout flags only releases the hold limit alone forced
          timeout_d = at_limit && !done && owner_req;
          gnt_d     = '0;
          valid_d   = 1'b0;
          hold_d    = '0;
          ptr_d     = id_q + IDW'(1);
          state_d   = IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;
  assign idle      = ~|req;

endmodule

// File: tb/tb_rr_grant_ctrl8.sv
// Directed bench for rr_grant_ctrl8: inputs change and outputs are checked on the falling clock edge.
module tb_rr_grant_ctrl8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       idle;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rr_grant_ctrl8 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .idle      (idle),
    .timeout   (timeout)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h01; done = 1'b0;
    cyc();
    vectors++;
    if (idle !== 1'b0 || gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: gnt=%h valid=%b idle=%b timeout=%b, want 00 0 0 0", gnt, gnt_valid, idle, timeout);
    end
    req = 8'h00;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      vectors++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || idle !== 1'b1 || timeout !== 1'b0 || gnt_id !== 3'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle[%0d]: gnt=%h id=%0d valid=%b idle=%b timeout=%b, want 00 0 0 1 0",
                 i, gnt, gnt_id, gnt_valid, idle, timeout);
      end
    end
  endtask

  task automatic test_two_req();
    logic [7:0] exp_gnt [4] = '{8'h01, 8'h00, 8'h80, 8'h00};
    logic [2:0] exp_id  [4] = '{3'd0, 3'd0, 3'd7, 3'd0};
    req = 8'h81; done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      vectors++;
      if (gnt !== exp_gnt[i] || gnt_valid !== (exp_gnt[i] != 8'h00) || timeout !== 1'b0 ||
          (exp_gnt[i] != 8'h00 && gnt_id !== exp_id[i])) begin
        miscompares++;
        $display("[TB] FAIL two_req[%0d]: gnt=%h id=%0d valid=%b timeout=%b, want gnt=%h id=%0d",
                 i, gnt, gnt_id, gnt_valid, timeout, exp_gnt[i], exp_id[i]);
      end
      done = (exp_gnt[i] != 8'h00);
    end
    done = 1'b0;
  endtask

  task automatic test_all_req();
    logic [2:0] id;
    req = 8'hFF; done = 1'b0;
    for (int k = 0; k < 9; k++) begin
      id = 3'(k % 8);
      cyc();
      vectors++;
      if (gnt !== (8'h01 << id) || gnt_id !== id || gnt_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL all_req_grant[%0d]: gnt=%h id=%0d valid=%b, want gnt=%h id=%0d valid=1",
                 k, gnt, gnt_id, gnt_valid, 8'h01 << id, id);
      end
      done = 1'b1;
      cyc();
      vectors++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL all_req_dead[%0d]: gnt=%h valid=%b timeout=%b, want 00 0 0", k, gnt, gnt_valid, timeout);
      end
      done = 1'b0;
      if (k == 8) req = 8'h00;
    end
    cyc();
  endtask

  task automatic test_timeout();
    req = 8'h08; done = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      vectors++;
      if (gnt !== 8'h08 || gnt_id !== 3'd3 || gnt_valid !== 1'b1 || timeout !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL timeout_hold[%0d]: gnt=%h id=%0d valid=%b timeout=%b, want 08 3 1 0",
                 c, gnt, gnt_id, gnt_valid, timeout);
      end
    end
    cyc();
    vectors++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_revoke: gnt=%h valid=%b timeout=%b, want 00 0 1", gnt, gnt_valid, timeout);
    end
    cyc();
    vectors++;
    if (gnt !== 8'h08 || gnt_id !== 3'd3 || timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_regrant: gnt=%h id=%0d timeout=%b, want 08 3 0", gnt, gnt_id, timeout);
    end
    done = 1'b1;
    cyc();
    done = 1'b0; req = 8'h18;
    cyc();
    vectors++;
    if (gnt !== 8'h10 || gnt_id !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL timeout_ptr4: gnt=%h id=%0d, want 10 4", gnt, gnt_id);
    end
    done = 1'b1;
    cyc();
    done = 1'b0; req = 8'h00;
    cyc();
  endtask

  task automatic test_wrap();
    logic [7:0] reqs   [6] = '{8'h20, 8'h04, 8'h20, 8'h44, 8'h44, 8'h00};
    logic [2:0] exp_id [5] = '{3'd5, 3'd2, 3'd5, 3'd6, 3'd2};
    done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req = reqs[i];
      cyc();
      vectors++;
      if (gnt !== (8'h01 << exp_id[i]) || gnt_id !== exp_id[i] || gnt_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL wrap_grant[%0d]: gnt=%h id=%0d valid=%b, want id=%0d", i, gnt, gnt_id, gnt_valid, exp_id[i]);
      end
      // id 5 releases by withdrawing its request, the others by done
      if (exp_id[i] == 3'd5) req = 8'h00;
      else done = 1'b1;
      cyc();
      vectors++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL wrap_release[%0d]: gnt=%h valid=%b timeout=%b, want 00 0 0", i, gnt, gnt_valid, timeout);
      end
      done = 1'b0;
    end
    req = reqs[5];
  endtask

  task automatic test_reset_busy();
    req = 8'h20; done = 1'b0;
    cyc();
    req = 8'h2F;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (gnt !== 8'h20 || gnt_id !== 3'd5 || gnt_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL busy_hold[%0d]: gnt=%h id=%0d valid=%b, want 20 5 1", i, gnt, gnt_id, gnt_valid);
      end
      if (i < 3) cyc();
    end
    rst = 1'b1;
    cyc();
    vectors++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_id !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL busy_reset: gnt=%h id=%0d valid=%b timeout=%b, want 00 0 0 0", gnt, gnt_id, gnt_valid, timeout);
    end
    rst = 1'b0; req = 8'h22; done = 1'b1;
    cyc();
    vectors++;
    if (gnt !== 8'h02 || gnt_id !== 3'd1 || gnt_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL post_reset_grant: gnt=%h id=%0d valid=%b, want 02 1 1", gnt, gnt_id, gnt_valid);
    end
    cyc();
    done = 1'b0;
    cyc();
    vectors++;
    if (gnt !== 8'h20 || gnt_id !== 3'd5) begin
      miscompares++;
      $display("[TB] FAIL post_reset_next: gnt=%h id=%0d, want 20 5", gnt, gnt_id);
    end
    req = 8'h00;
    cyc();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    test_reset();
    test_two_req();
    test_all_req();
    test_timeout();
    test_wrap();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
